// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode encodings and flag type for the CPU pipeline
package cpu_pkg;
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLL    = 5'b00101;
    localparam logic [4:0] OP_SRL    = 5'b00110;
    localparam logic [4:0] OP_BRANCH = 5'b00111;
    localparam logic [4:0] OP_IMML   = 5'b01000;
    localparam logic [4:0] OP_IMMH   = 5'b01001;
    localparam logic [4:0] OP_LOAD   = 5'b01010;
    localparam logic [4:0] OP_STORE  = 5'b01011;
    localparam logic [4:0] OP_DBLOAD = 5'b01100;
    localparam logic [4:0] OP_DBST   = 5'b01101;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } nvz_t;
endpackage

// File: rtl/execute_stage_alu16.sv
// alu16: combinational 16-bit ALU producing result and N/V/Z candidates
module alu16
    import cpu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] imm,
    output logic [15:0] result,
    output nvz_t        flags
);
    // Operation select, then flags derived from the truncated result
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:    result = a + b;
            OP_SUB:    result = a - b;
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_SLL:    result = a << b[3:0];
            OP_SRL:    result = a >> b[3:0];
            OP_IMML:   result = {a[15:8], imm[7:0]};
            OP_IMMH:   result = {imm[15:8], a[7:0]};
            OP_LOAD, OP_STORE, OP_DBLOAD, OP_DBST: result = a + imm;
            default:   result = '0;
        endcase
        flags.n = result[15];
        flags.z = (result == '0);
        flags.v = (op == OP_ADD) ? (a[15] == b[15]) && (result[15] != a[15]) :
                  (op == OP_SUB) ? (a[15] != b[15]) && (result[15] != a[15]) : 1'b0;
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, NVZ flag register and EX/MEM pipeline registers
module execute_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iStall,
    input  logic [4:0]        iOpcode,
    input  logic [DATA_W-1:0] iImm,
    input  logic [REG_AW-1:0] iSr1,
    input  logic [REG_AW-1:0] iSr2,
    input  logic [DATA_W-1:0] iData1,
    input  logic [DATA_W-1:0] iData2,
    input  logic              iAlutoReg,
    input  logic              iMemtoReg,
    input  logic              iBustoReg,
    input  logic [REG_AW-1:0] iWriteBackAddr,
    input  logic              iALUSrc,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iBusWrite,
    input  logic              iWb_en,
    input  logic [REG_AW-1:0] iWbAddr,
    input  logic [DATA_W-1:0] iWbData,
    output logic [2:0]        oNVZ,
    output logic [DATA_W-1:0] oResult,
    output logic [DATA_W-1:0] oStoreData,
    output logic              oAlutoReg,
    output logic              oMemtoReg,
    output logic              oBustoReg,
    output logic [REG_AW-1:0] oWriteBackAddr,
    output logic              oMemRead,
    output logic              oMemWrite,
    output logic              oBusWrite
);
    logic [DATA_W-1:0] op1, op2, alu_result;
    nvz_t              alu_flags, flags;
    logic              bubble, branch, set_flags;

    // Forwarding priority: r0, then the EX result (newest), then MEM/WB, then the register file
    assign op1 = (iSr1 == '0) ? '0 :
                 (oAlutoReg && oWriteBackAddr == iSr1) ? oResult :
                 (iWb_en && iWbAddr == iSr1) ? iWbData : iData1;
    assign op2 = (iSr2 == '0) ? '0 :
                 (oAlutoReg && oWriteBackAddr == iSr2) ? oResult :
                 (iWb_en && iWbAddr == iSr2) ? iWbData : iData2;

    assign bubble    = iOpcode > OP_DBST;
    assign branch    = iOpcode == OP_BRANCH;
    assign set_flags = iOpcode <= OP_SRL;
    assign oNVZ      = flags;

    alu16 u_alu (
        .op     (iOpcode),
        .a      (op1),
        .b      (op2),
        .imm    (iImm),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // EX/MEM registers and flags; unknown opcodes become bubbles, branches never write back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags          <= '0;
            oResult        <= '0;
            oStoreData     <= '0;
            oAlutoReg      <= 1'b0;
            oMemtoReg      <= 1'b0;
            oBustoReg      <= 1'b0;
            oWriteBackAddr <= '0;
            oMemRead       <= 1'b0;
            oMemWrite      <= 1'b0;
            oBusWrite      <= 1'b0;
        end else if (!iStall) begin
            if (set_flags) flags <= alu_flags;
            oResult        <= alu_result;
            oStoreData     <= op2;
            oAlutoReg      <= iAlutoReg && !bubble && !branch;
            oMemtoReg      <= iMemtoReg && !bubble && !branch;
            oBustoReg      <= iBustoReg && !bubble && !branch;
            oWriteBackAddr <= bubble ? '0 : iWriteBackAddr;
            oMemRead       <= iMemRead && !bubble;
            oMemWrite      <= iMemWrite && !bubble;
            oBusWrite      <= iBusWrite && !bubble;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against a behavioural model
module tb_execute_stage;
    logic        clk, rst_n, iStall;
    logic [4:0]  iOpcode;
    logic [15:0] iImm, iData1, iData2, iWbData;
    logic [3:0]  iSr1, iSr2, iWriteBackAddr, iWbAddr;
    logic        iAlutoReg, iMemtoReg, iBustoReg, iALUSrc, iMemRead, iMemWrite, iBusWrite, iWb_en;
    logic [2:0]  oNVZ;
    logic [15:0] oResult, oStoreData;
    logic        oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite;
    logic [3:0]  oWriteBackAddr;

    int checks = 0;
    int failures = 0;

    logic [15:0] e_result, e_store;
    logic [2:0]  e_nvz;
    logic [3:0]  e_wba;
    logic        e_alu, e_mem, e_bus, e_mr, e_mw, e_bw;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .iStall(iStall), .iOpcode(iOpcode), .iImm(iImm),
        .iSr1(iSr1), .iSr2(iSr2), .iData1(iData1), .iData2(iData2),
        .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
        .iWriteBackAddr(iWriteBackAddr), .iALUSrc(iALUSrc), .iMemRead(iMemRead),
        .iMemWrite(iMemWrite), .iBusWrite(iBusWrite), .iWb_en(iWb_en), .iWbAddr(iWbAddr),
        .iWbData(iWbData), .oNVZ(oNVZ), .oResult(oResult), .oStoreData(oStoreData),
        .oAlutoReg(oAlutoReg), .oMemtoReg(oMemtoReg), .oBustoReg(oBustoReg),
        .oWriteBackAddr(oWriteBackAddr), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .oBusWrite(oBusWrite)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_result = 0; e_store = 0; e_nvz = 0; e_wba = 0;
        e_alu = 0; e_mem = 0; e_bus = 0; e_mr = 0; e_mw = 0; e_bw = 0;
    endtask

    function automatic logic [15:0] mfwd(input logic [3:0] s, input logic [15:0] d);
        if (s == 0) return 16'h0;
        if (e_alu && e_wba == s) return e_result;
        if (iWb_en && iWbAddr == s) return iWbData;
        return d;
    endfunction

    task automatic model_step();
        logic [15:0] a, b, r;
        logic v, bub, br;
        int s;
        if (iStall) return;
        a = mfwd(iSr1, iData1);
        b = mfwd(iSr2, iData2);
        r = 0;
        v = 0;
        case (iOpcode)
            5'd0: begin s = int'($signed(a)) + int'($signed(b)); r = s[15:0]; v = s > 32767 || s < -32768; end
            5'd1: begin s = int'($signed(a)) - int'($signed(b)); r = s[15:0]; v = s > 32767 || s < -32768; end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = a << b[3:0];
            5'd6: r = a >> b[3:0];
            5'd8: r = {a[15:8], iImm[7:0]};
            5'd9: r = {iImm[15:8], a[7:0]};
            5'd10, 5'd11, 5'd12, 5'd13: r = a + iImm;
            default: r = 0;
        endcase
        if (iOpcode <= 5'd6) e_nvz = {r[15], v, r == 16'h0};
        bub = iOpcode > 5'd13;
        br = iOpcode == 5'd7;
        e_result = r;
        e_store = b;
        e_alu = iAlutoReg && !bub && !br;
        e_mem = iMemtoReg && !bub && !br;
        e_bus = iBustoReg && !bub && !br;
        e_wba = bub ? 4'h0 : iWriteBackAddr;
        e_mr = iMemRead && !bub;
        e_mw = iMemWrite && !bub;
        e_bw = iBusWrite && !bub;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".result"}, oResult, e_result);
        chk({tag, ".store"}, oStoreData, e_store);
        chk({tag, ".nvz"}, 16'(oNVZ), 16'(e_nvz));
        chk({tag, ".wba"}, 16'(oWriteBackAddr), 16'(e_wba));
        chk({tag, ".ctl"}, {10'h0, oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite},
            {10'h0, e_alu, e_mem, e_bus, e_mr, e_mw, e_bw});
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic [4:0] op, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] imm,
                          input logic [3:0] wba, input logic alu, input logic mw);
        iOpcode = op; iSr1 = s1; iSr2 = s2; iData1 = d1; iData2 = d2; iImm = imm;
        iWriteBackAddr = wba; iAlutoReg = alu; iMemWrite = mw;
        iMemtoReg = 0; iBustoReg = 0; iMemRead = 0; iBusWrite = 0; iALUSrc = 0;
    endtask

    task automatic rand_inputs();
        iStall = ($urandom_range(0, 99) < 15);
        iOpcode = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 13)) : 5'($urandom_range(0, 31));
        iImm = 16'($urandom);
        iSr1 = 4'($urandom_range(0, 3));
        iSr2 = 4'($urandom_range(0, 3));
        iData1 = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
        iData2 = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
        iAlutoReg = 1'($urandom);
        iMemtoReg = 1'($urandom);
        iBustoReg = 1'($urandom);
        iWriteBackAddr = 4'($urandom_range(0, 3));
        iALUSrc = 1'($urandom);
        iMemRead = 1'($urandom);
        iMemWrite = 1'($urandom);
        iBusWrite = 1'($urandom);
        iWb_en = 1'($urandom);
        iWbAddr = 4'($urandom_range(0, 3));
        iWbData = 16'($urandom);
    endtask

    initial begin
        rst_n = 0;
        iStall = 0; iWb_en = 0; iWbAddr = 0; iWbData = 0;
        set_in(5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        set_in(5'd0, 4'd1, 4'd2, 16'h7FFF, 16'h0001, 16'h0, 4'd3, 1, 0);
        cycle("add_ovf");
        chk("add_ovf.spec_result", oResult, 16'h8000);
        chk("add_ovf.spec_nvz", 16'(oNVZ), 16'h0006);

        set_in(5'd1, 4'd3, 4'd3, 16'h5555, 16'h1234, 16'h0, 4'd4, 1, 0);
        cycle("sub_exex");
        chk("sub_exex.spec_result", oResult, 16'h0000);
        chk("sub_exex.spec_nvz", 16'(oNVZ), 16'h0001);

        iWb_en = 1; iWbAddr = 4'd2; iWbData = 16'h00AA;
        set_in(5'd3, 4'd0, 4'd2, 16'h1111, 16'hFFFF, 16'h0, 4'd5, 1, 0);
        cycle("or_wbfwd");
        chk("or_wbfwd.spec_result", oResult, 16'h00AA);
        iWb_en = 0;

        set_in(5'd9, 4'd6, 4'd0, 16'h1234, 16'h0, 16'hAB00, 4'd6, 1, 0);
        cycle("immh");
        chk("immh.spec_result", oResult, 16'hAB34);
        chk("immh.spec_nvz", 16'(oNVZ), 16'h0000);

        iStall = 1;
        set_in(5'd11, 4'd7, 4'd8, 16'h1000, 16'hBEEF, 16'h0020, 4'd0, 0, 1);
        cycle("store_stall1");
        cycle("store_stall2");
        chk("store_stall.held", oResult, 16'hAB34);
        iStall = 0;
        cycle("store");
        chk("store.spec_addr", oResult, 16'h1020);
        chk("store.spec_data", oStoreData, 16'hBEEF);
        chk("store.spec_mw", 16'(oMemWrite), 16'h0001);

        iWb_en = 1; iWbAddr = 4'd3; iWbData = 16'h0F0F;
        set_in(5'd0, 4'd3, 4'd3, 16'h0001, 16'h0001, 16'h0, 4'd3, 1, 0);
        cycle("add_r3");
        set_in(5'd2, 4'd3, 4'd0, 16'h0, 16'h0, 16'h0, 4'd1, 1, 0);
        cycle("and_ex_beats_wb");
        iWb_en = 0;

        set_in(5'd31, 4'd1, 4'd2, 16'h1234, 16'h4321, 16'h0, 4'd9, 1, 1);
        iMemRead = 1; iBusWrite = 1; iMemtoReg = 1; iBustoReg = 1;
        cycle("bubble");

        set_in(5'd0, 4'd1, 4'd2, 16'h0102, 16'h0304, 16'h0, 4'd3, 1, 0);
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check_all("reset_mid");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
